// File: rtl/fc_layer.sv
// Sequential dense layer: one MAC per cycle over a flattened input map, then per-output bias,
// round-half-up and saturation. Optional macro FC_RELU_EN clamps negative logits to zero.
module fc_layer #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned FRAC_BITS     = 8,
  parameter int unsigned IN_DIM_HEIGHT = 16,
  parameter int unsigned IN_DIM_WIDTH  = 16,
  parameter int unsigned NUM_OUTPUTS   = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] input_feature_map [0:IN_DIM_HEIGHT-1][0:IN_DIM_WIDTH-1],
  input  logic                    w_wr_en,
  input  logic [$clog2(NUM_OUTPUTS*IN_DIM_HEIGHT*IN_DIM_WIDTH)-1:0] w_wr_addr,
  input  logic signed [WIDTH-1:0] w_wr_data,
  input  logic                    b_wr_en,
  input  logic [$clog2(NUM_OUTPUTS)-1:0] b_wr_addr,
  input  logic signed [WIDTH-1:0] b_wr_data,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] logits [0:NUM_OUTPUTS-1]
);

  localparam int unsigned N     = IN_DIM_HEIGHT * IN_DIM_WIDTH;
  localparam int unsigned Total = NUM_OUTPUTS * N;
  localparam int unsigned WAW   = $clog2(Total);
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OW    = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned AW    = 2 * WIDTH + $clog2(N) + 1;
  localparam int unsigned VW    = AW + 2;

  localparam logic signed [VW-1:0] RoundC =
      (FRAC_BITS > 0) ? (VW'(1) << (FRAC_BITS - 1)) : '0;
  localparam logic signed [WIDTH-1:0] OutMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] OutMin = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StMac   = 3'd2;
  localparam logic [2:0] StFinal = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [KW-1:0]        k_q, k_d;
  logic [OW-1:0]        o_q, o_d;
  logic [WAW-1:0]       waddr_q, waddr_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 logit_we;
  logic signed [WIDTH-1:0] logits_q [0:NUM_OUTPUTS-1];

  logic signed [WIDTH-1:0] w_mem  [0:Total-1];
  logic signed [WIDTH-1:0] b_mem  [0:NUM_OUTPUTS-1];
  logic signed [WIDTH-1:0] in_buf [0:N-1];

  logic signed [PW-1:0]    prod;
  logic signed [VW-1:0]    v_sum, v_shr;
  logic signed [WIDTH-1:0] res;

  // Memories and the input snapshot carry no reset; they only change while idle.
  always_ff @(posedge clk) begin
    if (!rst && state_q == StIdle) begin
      if (w_wr_en && 32'(w_wr_addr) < Total) w_mem[w_wr_addr] <= w_wr_data;
      if (b_wr_en && 32'(b_wr_addr) < NUM_OUTPUTS) b_mem[b_wr_addr] <= b_wr_data;
      if (start) begin
        for (int unsigned r = 0; r < IN_DIM_HEIGHT; r++) begin
          for (int unsigned c = 0; c < IN_DIM_WIDTH; c++) begin
            in_buf[KW'(r * IN_DIM_WIDTH + c)] <= input_feature_map[r][c];
          end
        end
      end
    end
  end

  assign prod  = PW'(in_buf[k_q]) * PW'(w_mem[waddr_q]);
  assign v_sum = VW'(acc_q) + (VW'(b_mem[o_q]) <<< FRAC_BITS) + RoundC;
  assign v_shr = v_sum >>> FRAC_BITS;

  always_comb begin
    if (v_shr > VW'(OutMax)) begin
      res = OutMax;
    end else if (v_shr < VW'(OutMin)) begin
      res = OutMin;
    end else begin
      res = v_shr[WIDTH-1:0];
    end
`ifdef FC_RELU_EN
    if (res < 0) res = '0;
`else
`endif
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    o_d      = o_q;
    waddr_d  = waddr_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    logit_we = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        k_d     = '0;
        o_d     = '0;
        waddr_d = '0;
        acc_d   = '0;
        state_d = StMac;
      end
      StMac: begin
        // Weight address runs contiguously across outputs, so it is never rewound mid-run.
        acc_d   = acc_q + AW'(prod);
        waddr_d = waddr_q + WAW'(1);
        if (k_q == KW'(N - 1)) begin
          k_d     = '0;
          state_d = StFinal;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StFinal: begin
        logit_we = 1'b1;
        acc_d    = '0;
        if (o_q == OW'(NUM_OUTPUTS - 1)) begin
          state_d = StDone;
        end else begin
          o_d     = o_q + OW'(1);
          state_d = StMac;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      o_q     <= '0;
      waddr_q <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) logits_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      o_q     <= o_d;
      waddr_q <= waddr_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (logit_we) logits_q[o_q] <= res;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign logits = logits_q;

endmodule

// File: tb/tb_fc_layer.sv
// Directed self-checking bench for fc_layer on a 2x2 map with two outputs (N=4).
module tb_fc_layer;

  localparam int H  = 2;
  localparam int WD = 2;
  localparam int NO = 2;

  logic clk = 1'b0;
  logic rst, start;
  logic signed [15:0] ifm [0:H-1][0:WD-1];
  logic               w_wr_en;
  logic [2:0]         w_wr_addr;
  logic signed [15:0] w_wr_data;
  logic               b_wr_en;
  logic [0:0]         b_wr_addr;
  logic signed [15:0] b_wr_data;
  logic               busy, done;
  logic signed [15:0] logits [0:NO-1];

  int   n_pass = 0;
  int   n_fail = 0;
  int   n_chk  = 0;
  int   done_cyc, pulses;
  logic busy_start, busy_done;

  fc_layer #(
    .WIDTH(16), .FRAC_BITS(8), .IN_DIM_HEIGHT(H), .IN_DIM_WIDTH(WD), .NUM_OUTPUTS(NO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .input_feature_map(ifm),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .b_wr_en(b_wr_en), .b_wr_addr(b_wr_addr), .b_wr_data(b_wr_data),
    .busy(busy), .done(done), .logits(logits)
  );

  always #5 clk = ~clk;

  function automatic logic signed [31:0] ex(input int v);
`ifdef FC_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ifm(input int v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < WD; c++) ifm[r][c] = 16'(v);
  endtask

  task automatic load_weights(input int w0, input int w1, input int b0, input int b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_wr_en   = 1'b1;
      w_wr_addr = 3'(i);
      w_wr_data = 16'((i < 4) ? w0 : w1);
    end
    @(negedge clk);
    w_wr_en   = 1'b0;
    b_wr_en   = 1'b1;
    b_wr_addr = 1'b0;
    b_wr_data = 16'(b0);
    @(negedge clk);
    b_wr_addr = 1'b1;
    b_wr_data = 16'(b1);
    @(negedge clk);
    b_wr_en = 1'b0;
  endtask

  // Pulses start and watches a bounded window; disturb pokes start/weight/inputs mid-run.
  task automatic run(input bit disturb);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    busy_start = busy;
    done_cyc   = -1;
    pulses     = 0;
    busy_done  = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses++;
        if (done_cyc < 0) begin
          done_cyc  = c;
          busy_done = busy;
        end
      end
      if (disturb && c == 3) begin
        start     = 1'b1;
        w_wr_en   = 1'b1;
        w_wr_addr = 3'd0;
        w_wr_data = 16'sh7fff;
        set_ifm(1000);
      end
      if (disturb && c == 4) begin
        start   = 1'b0;
        w_wr_en = 1'b0;
        set_ifm(256);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    set_ifm(256);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Weights loaded before reset must survive it.
    load_weights(128, -64, 64, 0);
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_logit0", logits[0], 0);
    check("reset_logit1", logits[1], 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk) rst = 1'b0;

    run(1'b0);
    check("basic_busy_start", busy_start, 1);
    check("basic_done_cycle", done_cyc, 12);
    check("basic_done_pulses", pulses, 1);
    check("basic_busy_at_done", busy_done, 0);
    check("basic_logit0", logits[0], ex(576));
    check("basic_logit1", logits[1], ex(-256));

    run(1'b1);
    check("proto_done_cycle", done_cyc, 12);
    check("proto_logit0", logits[0], ex(576));
    check("proto_logit1", logits[1], ex(-256));
    run(1'b0);
    check("proto_after_logit0", logits[0], ex(576));
    check("proto_after_logit1", logits[1], ex(-256));

    // Abort at cycle 5 of a run.
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_done_pulses", pulses, 0);
    check("abort_busy", busy, 0);
    check("abort_logit0", logits[0], 0);
    check("abort_logit1", logits[1], 0);
    run(1'b0);
    check("rerun_logit0", logits[0], ex(576));
    check("rerun_logit1", logits[1], ex(-256));

    set_ifm(25600);
    load_weights(25600, 25600, 0, 0);
    run(1'b0);
    check("sat_pos_logit0", logits[0], 32767);
    check("sat_pos_logit1", logits[1], 32767);
    load_weights(-25600, -25600, 0, 0);
    run(1'b0);
    check("sat_neg_logit0", logits[0], ex(-32768));
    check("sat_neg_logit1", logits[1], ex(-32768));

    set_ifm(256);
    load_weights(-256, -256, 0, 0);
    run(1'b0);
    check("relu_logit0", logits[0], ex(-1024));
    check("relu_logit1", logits[1], ex(-1024));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
